mem_axi_master: RTL and testbench
=================================

MEM_AXI_MASTER -- requirements
Module: mem_axi_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024, cycles allowed per AXI transaction before abort; 0 disables timeout.
REQ-002 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port mem_valid  in  1  native request valid, held until mem_ready.
REQ-005 SHALL have port mem_instr  in  1  request is an instruction fetch.
REQ-006 SHALL have port mem_ready  out  1  one-cycle completion pulse.
REQ-007 SHALL have port mem_addr  in  32  byte address.
REQ-008 SHALL have port mem_wdata  in  32  write data.
REQ-009 SHALL have port mem_wstrb  in  4  byte enables; 0 = read.
REQ-010 SHALL have port mem_rdata  out  32  read data, valid while mem_ready.
REQ-011 SHALL have port mem_err  out  1  timeout abort flag, valid while mem_ready.
REQ-012 SHALL have ports mem_axi_awvalid out 1, mem_axi_awready in 1, mem_axi_awaddr out 32, mem_axi_awprot out 3 (write address channel).
REQ-013 SHALL have ports mem_axi_wvalid out 1, mem_axi_wready in 1, mem_axi_wdata out 32, mem_axi_wstrb out 4 (write data channel).
REQ-014 SHALL have ports mem_axi_bvalid in 1, mem_axi_bready out 1 (write response).
REQ-015 SHALL have ports mem_axi_arvalid out 1, mem_axi_arready in 1, mem_axi_araddr out 32, mem_axi_arprot out 3 (read address).
REQ-016 SHALL have ports mem_axi_rvalid in 1, mem_axi_rready out 1, mem_axi_rdata in 32 (read data).

Function
REQ-017 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE; all AXI and native outputs registered.
REQ-018 IDLE: on edge with mem_valid=1, latch addr/wdata/wstrb/instr; wstrb==0 -> RD_ADDR, else -> WR_REQ; only one transaction outstanding, ever.
REQ-019 RD_ADDR: arvalid=1, araddr=latched addr, arprot={instr,2'b00}; on arvalid&&arready edge -> RD_DATA with arvalid=0.
REQ-020 RD_DATA: rready=1; on rvalid&&rready edge capture rdata into mem_rdata, -> DONE.
REQ-021 WR_REQ: awvalid and wvalid raised together on entry, awprot=3'b000; each drops independently on its own handshake edge (aw_done/w_done flags); both done (same or different edges) -> WR_RESP.
REQ-022 WR_RESP: bready=1; on bvalid&&bready edge -> DONE; mem_rdata unchanged on writes.
REQ-023 DONE: mem_ready=1 for exactly one cycle, -> IDLE; mem_valid sampled again only in IDLE.
REQ-024 Zero-wait responder latency: read mem_ready high in 4th cycle after mem_valid sample edge (IDLE, RD_ADDR, RD_DATA, DONE); write same.
REQ-025 Valid signals SHALL never deassert before handshake except on timeout or reset; address/data stable while valid.
REQ-026 Timeout: 16-bit counter clears on leaving IDLE, increments each cycle in RD_ADDR/RD_DATA/WR_REQ/WR_RESP; at count==TIMEOUT-1 drop all valids/readies, mem_rdata=32'hFFFF_FFFF, mem_err=1, -> DONE; mem_err=0 on normal completion.
REQ-027 Inputs bvalid/rvalid arriving in IDLE or wrong state SHALL be ignored (ready low).

Reset
REQ-028 resetn low SHALL immediately force IDLE, all valid/ready/mem_ready/mem_err=0, mem_rdata=0, flags and counter 0, including mid-transaction; no pending request resumes after release.

Structure
REQ-029 State encoding and PROT constants (PROT_INSN=3'b100, PROT_DATA=3'b000) SHALL live in package mem_axi_pkg.
REQ-030 SHALL be a single module; no sub-module.

Verification
REQ-031 Read 0x0000_0010, wstrb=0, responder always ready, rdata=0x1234_5678 -> arprot=3'b000, mem_ready in 4th cycle, mem_rdata=0x1234_5678, mem_err=0.
REQ-032 Fetch with mem_instr=1 -> arprot=3'b100.
REQ-033 Write 0x1000_0000 data 0x41 wstrb=4'b0001, wready 3 cycles after awready -> awvalid drops first, wvalid held until its handshake, one mem_ready after bvalid.
REQ-034 TIMEOUT=8, responder never asserts arready -> arvalid held 8 cycles then low, mem_ready with mem_err=1, mem_rdata=0xFFFF_FFFF.
REQ-035 resetn low during RD_DATA -> all outputs 0 asynchronously, IDLE after release, no mem_ready.
REQ-036 Randomized ready/valid delays (xorshift64), 1000 mixed transactions -> data matches model, no protocol violations.

Source files
------------

// File: rtl/mem_axi_pkg.sv
// Shared state encoding and AXI protection encodings for the native-to-AXI master.
package mem_axi_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_REQ  = 3'd3,
      WR_RESP = 3'd4,
      DONE    = 3'd5
   } state_t;

   localparam logic [2:0] PROT_INSN = 3'b100;
   localparam logic [2:0] PROT_DATA = 3'b000;

endpackage

// File: rtl/mem_axi_master.sv
// Bridges a single-outstanding native memory request onto AXI4-Lite; zero-wait latency is 4 cycles
// from the sampling edge, ready/valid handshakes stall the FSM, a per-transaction timeout aborts with mem_err.
module mem_axi_master
   import mem_axi_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   input  logic        mem_instr,
   output logic        mem_ready,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   output logic        mem_err,
   output logic        mem_axi_awvalid,
   input  logic        mem_axi_awready,
   output logic [31:0] mem_axi_awaddr,
   output logic [2:0]  mem_axi_awprot,
   output logic        mem_axi_wvalid,
   input  logic        mem_axi_wready,
   output logic [31:0] mem_axi_wdata,
   output logic [3:0]  mem_axi_wstrb,
   input  logic        mem_axi_bvalid,
   output logic        mem_axi_bready,
   output logic        mem_axi_arvalid,
   input  logic        mem_axi_arready,
   output logic [31:0] mem_axi_araddr,
   output logic [2:0]  mem_axi_arprot,
   input  logic        mem_axi_rvalid,
   output logic        mem_axi_rready,
   input  logic [31:0] mem_axi_rdata
);

   state_t      state;
   logic [15:0] tcnt;
   logic        aw_done;
   logic        w_done;
   logic        aw_hs;
   logic        w_hs;
   logic        tmo;

   assign aw_hs = mem_axi_awvalid && mem_axi_awready;
   assign w_hs  = mem_axi_wvalid && mem_axi_wready;
   assign tmo   = (TIMEOUT != 0) && (tcnt == 16'(TIMEOUT - 1));

   // Writes never carry the instruction attribute.
   assign mem_axi_awprot = PROT_DATA;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state           <= IDLE;
         tcnt            <= '0;
         aw_done         <= 1'b0;
         w_done          <= 1'b0;
         mem_ready       <= 1'b0;
         mem_err         <= 1'b0;
         mem_rdata       <= '0;
         mem_axi_awvalid <= 1'b0;
         mem_axi_awaddr  <= '0;
         mem_axi_wvalid  <= 1'b0;
         mem_axi_wdata   <= '0;
         mem_axi_wstrb   <= '0;
         mem_axi_bready  <= 1'b0;
         mem_axi_arvalid <= 1'b0;
         mem_axi_araddr  <= '0;
         mem_axi_arprot  <= '0;
         mem_axi_rready  <= 1'b0;
      end else begin
         mem_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_valid) begin
                  mem_axi_awaddr <= mem_addr;
                  mem_axi_araddr <= mem_addr;
                  mem_axi_wdata  <= mem_wdata;
                  mem_axi_wstrb  <= mem_wstrb;
                  mem_axi_arprot <= mem_instr ? PROT_INSN : PROT_DATA;
                  tcnt           <= '0;
                  aw_done        <= 1'b0;
                  w_done         <= 1'b0;
                  if (mem_wstrb == 4'b0000) begin
                     mem_axi_arvalid <= 1'b1;
                     state           <= RD_ADDR;
                  end else begin
                     mem_axi_awvalid <= 1'b1;
                     mem_axi_wvalid  <= 1'b1;
                     state           <= WR_REQ;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               if (tmo) begin
                  // Abort wins over a handshake landing on the same edge.
                  mem_axi_arvalid <= 1'b0;
                  mem_axi_rready  <= 1'b0;
                  mem_axi_awvalid <= 1'b0;
                  mem_axi_wvalid  <= 1'b0;
                  mem_axi_bready  <= 1'b0;
                  mem_rdata       <= 32'hFFFF_FFFF;
                  mem_err         <= 1'b1;
                  mem_ready       <= 1'b1;
                  state           <= DONE;
               end else begin
                  tcnt <= tcnt + 16'd1;
                  case (state)
                     RD_ADDR: begin
                        if (mem_axi_arvalid && mem_axi_arready) begin
                           mem_axi_arvalid <= 1'b0;
                           mem_axi_rready  <= 1'b1;
                           state           <= RD_DATA;
                        end
                     end
                     RD_DATA: begin
                        if (mem_axi_rvalid && mem_axi_rready) begin
                           mem_axi_rready <= 1'b0;
                           mem_rdata      <= mem_axi_rdata;
                           mem_err        <= 1'b0;
                           mem_ready      <= 1'b1;
                           state          <= DONE;
                        end
                     end
                     WR_REQ: begin
                        if (aw_hs) begin
                           mem_axi_awvalid <= 1'b0;
                           aw_done         <= 1'b1;
                        end
                        if (w_hs) begin
                           mem_axi_wvalid <= 1'b0;
                           w_done         <= 1'b1;
                        end
                        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                           mem_axi_bready <= 1'b1;
                           state          <= WR_RESP;
                        end
                     end
                     WR_RESP: begin
                        if (mem_axi_bvalid && mem_axi_bready) begin
                           mem_axi_bready <= 1'b0;
                           mem_err        <= 1'b0;
                           mem_ready      <= 1'b1;
                           state          <= DONE;
                        end
                     end
                     default: begin
                     end
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_axi_master.sv
// Drives the native port against a behavioural AXI slave memory and a word-level reference memory.
module tb_mem_axi_master;

   logic        clk = 1'b0;
   logic        resetn;
   logic        mem_valid, mem_instr, mem_ready, mem_err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic [144:0] all_out;

   always #5 clk = ~clk;

   mem_axi_master #(.TIMEOUT(8)) dut (
      .clk(clk), .resetn(resetn),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata), .mem_err(mem_err),
      .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr), .mem_axi_awprot(awprot),
      .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
      .mem_axi_bvalid(bvalid), .mem_axi_bready(bready),
      .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr), .mem_axi_arprot(arprot),
      .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata)
   );

   assign all_out = {mem_ready, mem_err, mem_rdata, awvalid, awaddr, awprot, wvalid, wdata, wstrb,
                     bready, arvalid, araddr, arprot, rready};

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdat;
      logic [3:0]  strb;
      logic        instr;
      int          dar, dr, daw, dw, db;
      int          lat;
      logic [31:0] rd;
      logic [2:0]  prot;
      int          arv, awv, wv;
   } vec_t;

   vec_t        tbl[8];
   int          total = 0, bad = 0, viol = 0;
   logic [63:0] rs;
   logic [31:0] slave_mem[16];
   logic [31:0] ref_mem[16];
   int          d_ar, d_r, d_aw, d_w, d_b, ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
   logic        r_pend, b_pend, aw_got, w_got, chk_proto, stray;
   logic [3:0]  r_idx, w_idx, w_stb, cur_wstrb;
   logic [31:0] w_dat, cur_addr, cur_wdata;
   logic        p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_rv, p_rr, p_bv, p_br;
   logic [31:0] p_araddr, p_awaddr, p_wdata;
   logic [3:0]  p_wstrb;
   logic [2:0]  p_arprot, p_awprot;
   int          cnt_arv, cnt_awv, cnt_wv, cnt_brd;
   int          o_lat;
   logic [31:0] o_rdata;
   logic        o_err;
   logic [2:0]  o_prot;

   function automatic logic [31:0] rnd();
      rs = rs ^ (rs << 13);
      rs = rs ^ (rs >> 7);
      rs = rs ^ (rs << 17);
      return rs[31:0];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One clock of slave behaviour, evaluated on the falling edge.
   task automatic step();
      @(negedge clk);
      if (resetn) begin
         if (p_arv && p_arr) begin
            r_pend = 1'b1; r_cnt = 0; r_idx = p_araddr[5:2]; o_prot = p_arprot;
            chk("araddr", p_araddr, cur_addr);
         end
         if (p_awv && p_awr) begin
            aw_got = 1'b1; w_idx = p_awaddr[5:2]; o_prot = p_awprot;
            chk("awaddr", p_awaddr, cur_addr);
         end
         if (p_wv && p_wr) begin
            w_got = 1'b1; w_dat = p_wdata; w_stb = p_wstrb;
            chk("wdata", p_wdata, cur_wdata);
            chk("wstrb", 32'(p_wstrb), 32'(cur_wstrb));
         end
         if (aw_got && w_got) begin
            for (int b = 0; b < 4; b++)
               if (w_stb[b]) slave_mem[w_idx][8*b +: 8] = w_dat[8*b +: 8];
            aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1; b_cnt = 0;
         end
         if (p_rv && p_rr) r_pend = 1'b0;
         if (p_bv && p_br) b_pend = 1'b0;
      end
      if (chk_proto) begin
         if (p_arv && !p_arr && (!arvalid || araddr != p_araddr || arprot != p_arprot)) viol++;
         if (p_awv && !p_awr && (!awvalid || awaddr != p_awaddr)) viol++;
         if (p_wv && !p_wr && (!wvalid || wdata != p_wdata || wstrb != p_wstrb)) viol++;
         if (rready && !r_pend) viol++;
         if (bready && !b_pend) viol++;
      end
      if (arvalid) cnt_arv++;
      if (awvalid) cnt_awv++;
      if (wvalid) cnt_wv++;
      if (bready) cnt_brd++;
      arready = arvalid && (ar_cnt >= d_ar);
      if (arvalid) ar_cnt++;
      awready = awvalid && (aw_cnt >= d_aw);
      if (awvalid) aw_cnt++;
      wready = wvalid && (w_cnt >= d_w);
      if (wvalid) w_cnt++;
      rvalid = r_pend && (r_cnt >= d_r);
      if (r_pend) r_cnt++;
      bvalid = b_pend && (b_cnt >= d_b);
      if (b_pend) b_cnt++;
      if (stray) begin
         rvalid = 1'b1; bvalid = 1'b1;
      end
      rdata = rvalid ? slave_mem[r_idx] : rnd();
      p_arv = arvalid; p_arr = arready; p_awv = awvalid; p_awr = awready;
      p_wv = wvalid; p_wr = wready; p_rv = rvalid; p_rr = rready; p_bv = bvalid; p_br = bready;
      p_araddr = araddr; p_awaddr = awaddr; p_wdata = wdata; p_wstrb = wstrb;
      p_arprot = arprot; p_awprot = awprot;
   endtask

   task automatic start_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                            input logic ins, input int dar, input int dr, input int daw,
                            input int dw, input int db);
      d_ar = dar; d_r = dr; d_aw = daw; d_w = dw; d_b = db;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      r_pend = 1'b0; b_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
      cnt_arv = 0; cnt_awv = 0; cnt_wv = 0; cnt_brd = 0; o_prot = 3'b111;
      cur_addr = a; cur_wdata = wd; cur_wstrb = st;
      mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = st; mem_instr = ins;
   endtask

   task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                          input logic ins, input int dar, input int dr, input int daw,
                          input int dw, input int db);
      int  cyc;
      logic done;
      start_txn(a, wd, st, ins, dar, dr, daw, dw, db);
      cyc = 1;
      done = 1'b0;
      while (!done && cyc < 40) begin
         step();
         cyc++;
         if (mem_ready) done = 1'b1;
      end
      chk("txn_completes", 32'(done), 32'(1));
      o_lat = cyc; o_rdata = mem_rdata; o_err = mem_err;
      mem_valid = 1'b0; mem_addr = rnd(); mem_wdata = rnd();
      step();
      chk("ready_one_cycle", 32'(mem_ready), 32'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      logic [31:0] r, a, wd, exp_rd, last_rd;
      logic [3:0]  st, idx;
      logic        ins, saw;
      int          dar, dr, daw, dw, db, gap, lat_exp, k;

      rs = {$urandom, $urandom} | 64'd1;
      resetn = 1'b0;
      mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0;
      {p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_rv, p_rr, p_bv, p_br} = '0;
      p_araddr = '0; p_awaddr = '0; p_wdata = '0; p_wstrb = '0; p_arprot = '0; p_awprot = '0;
      d_ar = 0; d_r = 0; d_aw = 0; d_w = 0; d_b = 0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      r_pend = 1'b0; b_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; r_idx = '0; w_idx = '0;
      w_dat = '0; w_stb = '0; cur_addr = '0; cur_wdata = '0; cur_wstrb = '0;
      chk_proto = 1'b1; stray = 1'b0;
      for (int i = 0; i < 16; i++) slave_mem[i] = 32'hC0DE_0000 | 32'(i);
      slave_mem[4] = 32'h1234_5678;

      //        addr           wdat           strb    ins   dar dr daw dw db lat rd             prot    arv awv wv
      tbl[0] = '{32'h0000_0010, 32'h0,         4'b0000, 1'b0, 0, 0, 0, 0, 0, 4, 32'h1234_5678, 3'b000, 1, 0, 0};
      tbl[1] = '{32'h0000_0014, 32'h0,         4'b0000, 1'b1, 0, 0, 0, 0, 0, 4, 32'hC0DE_0005, 3'b100, 1, 0, 0};
      tbl[2] = '{32'h1000_0000, 32'h41,        4'b0001, 1'b0, 0, 0, 0, 3, 0, 7, 32'hC0DE_0005, 3'b000, 0, 1, 4};
      tbl[3] = '{32'h1000_0000, 32'h0,         4'b0000, 1'b0, 0, 0, 0, 0, 0, 4, 32'hC0DE_0041, 3'b000, 1, 0, 0};
      tbl[4] = '{32'h0000_0024, 32'hDEADBEEF,  4'b0110, 1'b0, 0, 0, 2, 0, 2, 8, 32'hC0DE_0041, 3'b000, 0, 3, 1};
      tbl[5] = '{32'h0000_0024, 32'h0,         4'b0000, 1'b0, 2, 1, 0, 0, 0, 7, 32'hC0AD_BE09, 3'b000, 3, 0, 0};
      tbl[6] = '{32'h0000_0028, 32'h0BADF00D,  4'b1111, 1'b1, 0, 0, 0, 0, 0, 4, 32'hC0AD_BE09, 3'b000, 0, 1, 1};
      tbl[7] = '{32'h0000_0028, 32'h0,         4'b0000, 1'b1, 0, 2, 0, 0, 0, 6, 32'h0BAD_F00D, 3'b100, 1, 0, 0};

      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs_zero", 32'(|all_out), 32'(0));
      @(negedge clk);
      resetn = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_txn(tbl[i].addr, tbl[i].wdat, tbl[i].strb, tbl[i].instr,
                 tbl[i].dar, tbl[i].dr, tbl[i].daw, tbl[i].dw, tbl[i].db);
         chk($sformatf("vec%0d_latency", i), 32'(o_lat), 32'(tbl[i].lat));
         chk($sformatf("vec%0d_rdata", i), o_rdata, tbl[i].rd);
         chk($sformatf("vec%0d_err", i), 32'(o_err), 32'(0));
         chk($sformatf("vec%0d_prot", i), 32'(o_prot), 32'(tbl[i].prot));
         chk($sformatf("vec%0d_arvalid_cycles", i), 32'(cnt_arv), 32'(tbl[i].arv));
         chk($sformatf("vec%0d_awvalid_cycles", i), 32'(cnt_awv), 32'(tbl[i].awv));
         chk($sformatf("vec%0d_wvalid_cycles", i), 32'(cnt_wv), 32'(tbl[i].wv));
      end

      // Responses with nothing outstanding must not be accepted.
      stray = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("stray_ignored", 32'({rready, bready, mem_ready}), 32'(0));
      end
      stray = 1'b0;
      step();

      chk_proto = 1'b0;
      run_txn(32'h0000_0030, 32'h0, 4'b0000, 1'b0, 99, 0, 0, 0, 0);
      chk("rd_timeout_latency", 32'(o_lat), 32'(10));
      chk("rd_timeout_arvalid_cycles", 32'(cnt_arv), 32'(8));
      chk("rd_timeout_err", 32'(o_err), 32'(1));
      chk("rd_timeout_rdata", o_rdata, 32'hFFFF_FFFF);
      run_txn(32'h0000_002C, 32'h5, 4'b1111, 1'b0, 0, 0, 0, 0, 99);
      chk("wr_timeout_latency", 32'(o_lat), 32'(10));
      chk("wr_timeout_bready_cycles", 32'(cnt_brd), 32'(7));
      chk("wr_timeout_err", 32'(o_err), 32'(1));
      chk("wr_timeout_rdata", o_rdata, 32'hFFFF_FFFF);
      chk_proto = 1'b1;
      run_txn(32'h0000_0010, 32'h0, 4'b0000, 1'b0, 0, 0, 0, 0, 0);
      chk("after_timeout_err", 32'(o_err), 32'(0));
      chk("after_timeout_rdata", o_rdata, 32'h1234_5678);

      // Reset while waiting for read data.
      chk_proto = 1'b0;
      start_txn(32'h0000_0014, 32'h0, 4'b0000, 1'b0, 0, 99, 0, 0, 0);
      k = 0;
      while (!rready && k < 10) begin
         step();
         k++;
      end
      chk("reached_rd_data", 32'(rready), 32'(1));
      #2 resetn = 1'b0;
      #1 chk("async_reset_outputs_zero", 32'(|all_out), 32'(0));
      mem_valid = 1'b0;
      step();
      step();
      resetn = 1'b1;
      r_pend = 1'b0; b_pend = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (mem_ready || arvalid || awvalid || rready) saw = 1'b1;
      end
      chk("no_resume_after_reset", 32'(saw), 32'(0));
      chk_proto = 1'b1;

      for (int i = 0; i < 16; i++) ref_mem[i] = slave_mem[i];
      last_rd = 32'h0;
      for (int n = 0; n < 1000; n++) begin
         r = rnd();
         ins = r[1];
         idx = r[5:2];
         st = r[0] ? 4'b0000 : 4'(r[9:6] % 15 + 1);
         a = 32'h0000_0100 | {26'd0, idx, 2'b00};
         wd = rnd();
         r = rnd();
         dar = int'(r[7:0] % 3); dr = int'(r[15:8] % 3); daw = int'(r[23:16] % 3);
         dw = int'(r[31:24] % 3);
         r = rnd();
         db = int'(r[7:0] % 3); gap = int'(r[15:8] % 3);
         if (st == 4'b0000) begin
            exp_rd = ref_mem[idx];
            last_rd = exp_rd;
            lat_exp = 4 + dar + dr;
         end else begin
            for (int b = 0; b < 4; b++)
               if (st[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
            exp_rd = last_rd;
            lat_exp = 4 + ((daw > dw) ? daw : dw) + db;
         end
         repeat (gap) step();
         run_txn(a, wd, st, ins, dar, dr, daw, dw, db);
         chk("rand_rdata", o_rdata, exp_rd);
         chk("rand_err", 32'(o_err), 32'(0));
         chk("rand_latency", 32'(o_lat), 32'(lat_exp));
         chk("rand_prot", 32'(o_prot), (st == 4'b0000 && ins) ? 32'd4 : 32'd0);
      end

      chk("protocol_violations", 32'(viol), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
